// File: rtl/spm_ctrl_if.sv
// Operand/product handshake bundle for spm_ctrl.
// master = bus-side register block, slave = controller.
interface spm_ctrl_if #(
    parameter int WIDTH = 32
);
    logic               in_valid;
    logic               in_ready;
    logic [WIDTH-1:0]   in_x;
    logic [WIDTH-1:0]   in_y;
    logic               out_valid;
    logic               out_ready;
    logic [2*WIDTH-1:0] out_p;

    modport master (
        output in_valid, in_x, in_y, out_ready,
        input  in_ready, out_valid, out_p
    );

    modport slave (
        input  in_valid, in_x, in_y, out_ready,
        output in_ready, out_valid, out_p
    );
endinterface

// File: rtl/spm_ctrl.sv
// Sequencer for the serial-parallel multiplier array: loads x, streams y, collects product.
// Optional abort port and behaviour enabled by defining SPM_CTRL_ABORT_EN.
module spm_ctrl #(
    parameter int WIDTH  = 32,
    parameter bit SIGNED = 1'b1,
    parameter int P_LAT  = 1
) (
    input  logic             clk,
    input  logic             rst,
    spm_ctrl_if.slave        bus,
    output logic [WIDTH-1:0] spm_x,
    output logic             spm_y,
    output logic             spm_clr,
    input  logic             spm_p
`ifdef SPM_CTRL_ABORT_EN
    ,
    input  logic             abort
`endif
);

    localparam int NCYC = 2 * WIDTH + P_LAT;
    localparam int CW   = $clog2(NCYC);
    localparam logic [CW-1:0] LAST = CW'(NCYC - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CLR  = 2'd1;
    localparam logic [1:0] S_RUN  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]         state;
    logic [CW-1:0]      cnt;
    logic [WIDTH-1:0]   ysr;
    logic [2*WIDTH-2:0] psr;
    logic               fill;
    logic               abrt;
    logic               kill;
    logic               y_hi;

`ifdef SPM_CTRL_ABORT_EN
    assign abrt = abort;
`else
    assign abrt = 1'b0;
`endif

    assign kill = abrt && (state == S_CLR || state == S_RUN);
    assign fill = SIGNED ? ysr[WIDTH-1] : 1'b0;
    assign y_hi = (int'(cnt) + 1) >= 2 * WIDTH;
    assign bus.in_ready = (state == S_IDLE);

    // y is shifted arithmetically so bits above WIDTH become the sign fill.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= S_IDLE;
            cnt           <= '0;
            ysr           <= '0;
            psr           <= '0;
            spm_x         <= '0;
            spm_y         <= 1'b0;
            spm_clr       <= 1'b1;
            bus.out_valid <= 1'b0;
            bus.out_p     <= '0;
        end else begin
            spm_clr <= 1'b0;
            if (kill) begin
                state   <= S_IDLE;
                spm_y   <= 1'b0;
                spm_clr <= 1'b1;
            end else begin
                unique case (1'b1)
                    (state == S_IDLE): begin
                        if (bus.in_valid) begin
                            spm_x   <= bus.in_x;
                            ysr     <= bus.in_y;
                            spm_y   <= 1'b0;
                            spm_clr <= 1'b1;
                            state   <= S_CLR;
                        end
                    end
                    (state == S_CLR): begin
                        cnt   <= '0;
                        spm_y <= ysr[0];
                        ysr   <= {fill, ysr[WIDTH-1:1]};
                        state <= S_RUN;
                    end
                    (state == S_RUN): begin
                        if (int'(cnt) >= P_LAT)
                            psr <= {spm_p, psr[2*WIDTH-2:1]};
                        if (cnt == LAST) begin
                            bus.out_p     <= {spm_p, psr};
                            bus.out_valid <= 1'b1;
                            spm_y         <= 1'b0;
                            state         <= S_DONE;
                        end else begin
                            cnt   <= cnt + CW'(1);
                            spm_y <= y_hi ? 1'b0 : ysr[0];
                            ysr   <= {fill, ysr[WIDTH-1:1]};
                        end
                    end
                    (state == S_DONE): begin
                        if (bus.out_ready) begin
                            bus.out_valid <= 1'b0;
                            state         <= S_IDLE;
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule
